// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: EX forwarding, load-use stall, branch flush and data-memory wait/watchdog.
// Optional perf counters (stall cycles, flush events) enabled by defining HAZARD_PERF_CNT_EN.
//
// state    | meaning
// RUN      | no outstanding slow memory access
// MEM_WAIT | memory access pending, pipeline frozen, watchdog counting
module hazard_ctrl #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int MEM_TIMEOUT    = 15,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REG_ADDR_WIDTH-1:0] Rs1D_i,
    input  logic [REG_ADDR_WIDTH-1:0] Rs2D_i,
    input  logic [REG_ADDR_WIDTH-1:0] Rs1E_i,
    input  logic [REG_ADDR_WIDTH-1:0] Rs2E_i,
    input  logic [REG_ADDR_WIDTH-1:0] RdE_i,
    input  logic [REG_ADDR_WIDTH-1:0] RdM_i,
    input  logic [REG_ADDR_WIDTH-1:0] RdW_i,
    input  logic                      MemReadE_i,
    input  logic                      RegWriteM_i,
    input  logic                      RegWriteW_i,
    input  logic                      PCSrcE_i,
    input  logic                      MemReqM_i,
    input  logic                      MemReadyM_i,
    output logic [1:0]                ForwardAE_o,
    output logic [1:0]                ForwardBE_o,
    output logic                      StallF_o,
    output logic                      StallD_o,
    output logic                      StallE_o,
    output logic                      StallM_o,
    output logic                      FlushD_o,
    output logic                      FlushE_o,
    output logic                      FlushW_o,
`ifdef HAZARD_PERF_CNT_EN
    output logic [CNT_WIDTH-1:0]      StallCycles_o,
    output logic [CNT_WIDTH-1:0]      FlushEvents_o,
`endif
    output logic                      MemErr_o
);

    localparam int TW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TW-1:0] TLIM = TW'(MEM_TIMEOUT);

    typedef enum logic {RUN, MEM_WAIT} state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] tcnt, tcnt_nxt;
    logic          mem_stall_raw, mem_stall, lw_stall, err_set;

    function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_WIDTH-1:0] rs);
        if (RegWriteM_i && RdM_i != '0 && RdM_i == rs)
            return 2'b10;
        else if (RegWriteW_i && RdW_i != '0 && RdW_i == rs)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign ForwardAE_o = fwd_sel(Rs1E_i);
    assign ForwardBE_o = fwd_sel(Rs2E_i);

    assign lw_stall = MemReadE_i && RdE_i != '0 && (RdE_i == Rs1D_i || RdE_i == Rs2D_i);

    always_comb begin
        state_nxt     = state;
        tcnt_nxt      = tcnt;
        mem_stall_raw = 1'b0;
        err_set       = 1'b0;
        case (state)
            RUN: begin
                if (MemReqM_i && !MemReadyM_i) begin
                    mem_stall_raw = 1'b1;
                    state_nxt     = MEM_WAIT;
                    tcnt_nxt      = TW'(1);
                end
            end
            MEM_WAIT: begin
                if (MemReadyM_i) begin
                    state_nxt = RUN;
                    tcnt_nxt  = '0;
                end else if (tcnt == TLIM) begin
                    // watchdog expired: release the pipeline and flag the error
                    state_nxt = RUN;
                    tcnt_nxt  = '0;
                    err_set   = 1'b1;
                end else begin
                    mem_stall_raw = 1'b1;
                    tcnt_nxt      = tcnt + 1'b1;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            tcnt     <= '0;
            MemErr_o <= 1'b0;
        end else begin
            state <= state_nxt;
            tcnt  <= tcnt_nxt;
            if (err_set)
                MemErr_o <= 1'b1;
        end
    end

    // pipeline controls are held inactive for the whole time reset is asserted
    assign mem_stall = mem_stall_raw && !rst;

    always_comb begin
        StallM_o = mem_stall;
        StallE_o = mem_stall;
        StallF_o = mem_stall || (!rst && lw_stall && !PCSrcE_i);
        StallD_o = StallF_o;
        FlushD_o = !rst && PCSrcE_i && !mem_stall;
        FlushE_o = !rst && !mem_stall && (PCSrcE_i || lw_stall);
        FlushW_o = mem_stall;
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            StallCycles_o <= '0;
            FlushEvents_o <= '0;
        end else begin
            if (StallF_o && StallCycles_o != '1)
                StallCycles_o <= StallCycles_o + 1'b1;
            if (FlushD_o && FlushEvents_o != '1)
                FlushEvents_o <= FlushEvents_o + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed vectors push expected outputs, a negedge monitor pops and compares.
module tb_hazard_ctrl;

    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] rs1d = '0, rs2d = '0, rs1e = '0, rs2e = '0, rde = '0, rdm = '0, rdw = '0;
    logic          mem_read_e = 0, reg_write_m = 0, reg_write_w = 0, pc_src_e = 0, mem_req_m = 0, mem_ready_m = 0;
    logic [1:0]    fwd_a, fwd_b;
    logic          stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w, mem_err;
`ifdef HAZARD_PERF_CNT_EN
    logic [1:0]    stall_cycles, flush_events;
`endif

    hazard_ctrl #(.REG_ADDR_WIDTH(AW), .MEM_TIMEOUT(4), .CNT_WIDTH(2)) dut (
        .clk(clk), .rst(rst),
        .Rs1D_i(rs1d), .Rs2D_i(rs2d), .Rs1E_i(rs1e), .Rs2E_i(rs2e),
        .RdE_i(rde), .RdM_i(rdm), .RdW_i(rdw),
        .MemReadE_i(mem_read_e), .RegWriteM_i(reg_write_m), .RegWriteW_i(reg_write_w),
        .PCSrcE_i(pc_src_e), .MemReqM_i(mem_req_m), .MemReadyM_i(mem_ready_m),
        .ForwardAE_o(fwd_a), .ForwardBE_o(fwd_b),
        .StallF_o(stall_f), .StallD_o(stall_d), .StallE_o(stall_e), .StallM_o(stall_m),
        .FlushD_o(flush_d), .FlushE_o(flush_e), .FlushW_o(flush_w),
`ifdef HAZARD_PERF_CNT_EN
        .StallCycles_o(stall_cycles), .FlushEvents_o(flush_events),
`endif
        .MemErr_o(mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] v;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // expected word: {FwdA, FwdB, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr}
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t        e;
            logic [11:0] act;
            e   = exp_q.pop_front();
            act = {fwd_a, fwd_b, stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w, mem_err};
            n_checks++;
            if (act === e.v)
                n_pass++;
            else
                $display("FAIL %s: got %b expected %b", e.name, act, e.v);
        end
    end

    // c = {rst, MemReadE, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM}
    task automatic apply(input logic [AW-1:0] a_rs1d, a_rs2d, a_rs1e, a_rs2e, a_rde, a_rdm, a_rdw,
                         input logic [6:0] c, input logic [11:0] e, input string nm);
        exp_t x;
        @(posedge clk);
        #1;
        rs1d = a_rs1d; rs2d = a_rs2d; rs1e = a_rs1e; rs2e = a_rs2e;
        rde = a_rde; rdm = a_rdm; rdw = a_rdw;
        {rst, mem_read_e, reg_write_m, reg_write_w, pc_src_e, mem_req_m, mem_ready_m} = c;
        x.v = e;
        x.name = nm;
        exp_q.push_back(x);
    endtask

    initial begin
        // reset: controls forced low even with a pending slow request; forwarding stays live
        apply(0, 0, 5, 0, 0, 5, 0, 7'b1_0_1_0_0_1_0, 12'b10_00_0000_000_0, "reset");

        apply(0, 0, 5, 0, 0, 5, 5, 7'b0_0_1_1_0_0_0, 12'b10_00_0000_000_0, "fwd_m_prio");
        apply(0, 0, 5, 5, 0, 5, 5, 7'b0_0_0_1_0_0_0, 12'b01_01_0000_000_0, "fwd_w_only");
        apply(0, 0, 0, 0, 0, 0, 0, 7'b0_0_1_1_0_0_0, 12'b00_00_0000_000_0, "fwd_rd_zero");
        apply(0, 0, 4, 3, 0, 3, 3, 7'b0_0_1_1_0_0_0, 12'b00_10_0000_000_0, "fwd_b_m");
        apply(0, 0, 4, 3, 0, 3, 4, 7'b0_0_1_1_0_0_0, 12'b01_10_0000_000_0, "fwd_a_w_b_m");

        apply(0, 7, 0, 0, 7, 0, 0, 7'b0_1_0_0_0_0_0, 12'b00_00_1100_010_0, "lw_rs2");
        apply(0, 0, 0, 0, 0, 0, 0, 7'b0_1_0_0_0_0_0, 12'b00_00_0000_000_0, "lw_rd_zero");
        apply(7, 0, 0, 0, 7, 0, 0, 7'b0_1_0_0_1_0_0, 12'b00_00_0000_110_0, "branch_over_lw");
        apply(7, 0, 0, 0, 7, 0, 0, 7'b0_1_0_0_0_0_0, 12'b00_00_1100_010_0, "lw_rs1");

        apply(0, 0, 0, 0, 0, 0, 0, 7'b0_0_0_0_0_1_0, 12'b00_00_1111_001_0, "mwait_1");
        apply(0, 0, 0, 0, 0, 0, 0, 7'b0_0_0_0_1_1_0, 12'b00_00_1111_001_0, "mwait_2_br");
        apply(0, 0, 0, 0, 0, 0, 0, 7'b0_0_0_0_1_1_0, 12'b00_00_1111_001_0, "mwait_3_br");
        apply(0, 0, 0, 0, 0, 0, 0, 7'b0_0_0_0_1_1_1, 12'b00_00_0000_110_0, "mwait_release");
        apply(0, 0, 0, 0, 0, 0, 0, 7'b0_0_0_0_0_0_0, 12'b00_00_0000_000_0, "idle_after_wait");

        for (int i = 1; i <= 4; i++)
            apply(0, 0, 0, 0, 0, 0, 0, 7'b0_0_0_0_0_1_0, 12'b00_00_1111_001_0, $sformatf("wdog_stall_%0d", i));
        apply(0, 0, 0, 0, 0, 0, 0, 7'b0_0_0_0_0_1_0, 12'b00_00_0000_000_0, "wdog_release");
        apply(0, 0, 0, 0, 0, 0, 0, 7'b0_0_0_0_0_0_0, 12'b00_00_0000_000_1, "wdog_err_set");
        apply(0, 0, 0, 0, 0, 0, 0, 7'b0_0_0_0_0_0_0, 12'b00_00_0000_000_1, "wdog_err_sticky");

`ifdef HAZARD_PERF_CNT_EN
        @(negedge clk);
        n_checks++;
        if (stall_cycles === 2'd3) n_pass++;
        else $display("FAIL perf_stall_sat: got %0d expected 3", stall_cycles);
        n_checks++;
        if (flush_events === 2'd2) n_pass++;
        else $display("FAIL perf_flush_cnt: got %0d expected 2", flush_events);
`endif

        apply(0, 0, 0, 0, 0, 0, 0, 7'b0_0_0_0_0_1_0, 12'b00_00_1111_001_1, "rst_wait_1");
        apply(0, 0, 0, 0, 0, 0, 0, 7'b0_0_0_0_0_1_0, 12'b00_00_1111_001_1, "rst_wait_2");
        apply(0, 0, 0, 0, 0, 0, 0, 7'b1_0_0_0_0_1_0, 12'b00_00_0000_000_0, "rst_mid_wait");
        apply(0, 0, 0, 0, 0, 0, 0, 7'b0_0_0_0_0_1_0, 12'b00_00_1111_001_0, "post_rst_stall");
        apply(0, 0, 0, 0, 0, 0, 0, 7'b0_0_0_0_0_1_1, 12'b00_00_0000_000_0, "post_rst_release");
        apply(0, 0, 0, 0, 0, 0, 0, 7'b0_0_0_0_0_0_0, 12'b00_00_0000_000_0, "final_idle");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(posedge clk);
        if (exp_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
